// File: rtl/bus_map_pkg.sv
// ----------------------------------------------------------------------------
// bus_map_pkg
// Shared memory map and types for the 8-bit peripheral bus. The timer and IR
// blocks use the same constants, so every address used on the bus is defined
// here once.
//   NUM_IRQ        : number of interrupt lines watched by the servicer
//   IDLE_ADDR      : unmapped address parked on the bus while not accessing
//   TIMER_BASE     : timer value register (source for line 1)
//   TIMER_CLR_ADDR : timer clear; fires on address match alone
//   IR_CMD_ADDR    : IR transmitter command register (destination for line 1)
//   state_e        : servicer FSM states
// ----------------------------------------------------------------------------
package bus_map_pkg;

    localparam int NUM_IRQ = 2;

    localparam logic [7:0] IDLE_ADDR      = 8'hFF;
    localparam logic [7:0] TIMER_BASE     = 8'hF0;
    localparam logic [7:0] TIMER_CLR_ADDR = 8'hF2;
    localparam logic [7:0] IR_CMD_ADDR    = 8'h90;

    // Per-line routing: line 0 moves 0xA0 -> 0xB0, line 1 moves timer -> IR.
    localparam logic [7:0] SRC_ADDR0 = 8'hA0;
    localparam logic [7:0] DST_ADDR0 = 8'hB0;
    localparam logic [7:0] SRC_ADDR1 = TIMER_BASE;
    localparam logic [7:0] DST_ADDR1 = IR_CMD_ADDR;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACK     = 3'd1,
        ST_RD_ADDR = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_WR      = 3'd4
    } state_e;

    function automatic logic [7:0] src_addr(input logic line);
        return line ? SRC_ADDR1 : SRC_ADDR0;
    endfunction

    function automatic logic [7:0] dst_addr(input logic line);
        return line ? DST_ADDR1 : DST_ADDR0;
    endfunction

endpackage

// File: rtl/bus_irq_servicer_if.sv
// ----------------------------------------------------------------------------
// bus_irq_servicer_if
// Address/strobe and interrupt raise/ack signals of the shared peripheral bus.
// The 8-bit data bus is a resolved tristate net and is carried as a plain
// inout port on the servicer instead.
//   BUS_ADDR             : bus address (initiator -> peripherals)
//   BUS_WE               : write strobe (initiator -> peripherals)
//   BUS_INTERRUPTS_RAISE : level requests (peripherals -> initiator)
//   BUS_INTERRUPTS_ACK   : one-hot, one-cycle acknowledge (initiator -> peripherals)
// ----------------------------------------------------------------------------
interface bus_irq_servicer_if;
    import bus_map_pkg::*;

    logic [7:0]         BUS_ADDR;
    logic               BUS_WE;
    logic [NUM_IRQ-1:0] BUS_INTERRUPTS_RAISE;
    logic [NUM_IRQ-1:0] BUS_INTERRUPTS_ACK;

    modport master (
        output BUS_ADDR,
        output BUS_WE,
        output BUS_INTERRUPTS_ACK,
        input  BUS_INTERRUPTS_RAISE
    );

    modport slave (
        input  BUS_ADDR,
        input  BUS_WE,
        input  BUS_INTERRUPTS_ACK,
        output BUS_INTERRUPTS_RAISE
    );

endinterface

// File: rtl/bus_irq_servicer.sv
// ----------------------------------------------------------------------------
// bus_irq_servicer
// Bus initiator that services peripheral interrupts without the CPU: picks a
// pending line (line 0 wins), acknowledges it, reads the line's source
// register and writes the byte to the line's destination register.
//   CLK       : clock, all state on posedge
//   RESET     : asynchronous active-low reset
//   BUS_DATA  : shared 8-bit tristate data bus, driven only while writing
//   bus       : address / write strobe / raise / ack (master side)
//   ENABLE    : per-line service mask
//   BUSY      : high whenever a service is in progress
//   DONE      : one-cycle pulse in the write cycle
//   LAST_DATA : last byte read
//   LAST_SRC  : line index of the last service
// ----------------------------------------------------------------------------
module bus_irq_servicer
    import bus_map_pkg::*;
(
    input  logic                CLK,
    input  logic                RESET,
    inout  wire  [7:0]          BUS_DATA,
    bus_irq_servicer_if.master  bus,
    input  logic [NUM_IRQ-1:0]  ENABLE,
    output logic                BUSY,
    output logic                DONE,
    output logic [7:0]          LAST_DATA,
    output logic                LAST_SRC
);

    state_e      state_q, state_d;
    logic        cur_q, cur_d;
    logic [7:0]  last_data_q, last_data_d;
    logic        last_src_q, last_src_d;

    logic [NUM_IRQ-1:0] pending;
    logic               drive_en;

    // Requests are level and not latched: only what is high while IDLE counts.
    assign pending = bus.BUS_INTERRUPTS_RAISE & ENABLE;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= ST_IDLE;
            cur_q       <= 1'b0;
            last_data_q <= 8'h00;
            last_src_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            last_data_q <= last_data_d;
            last_src_q  <= last_src_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        last_data_d = last_data_q;
        last_src_d  = last_src_q;

        case (state_q)
            ST_IDLE: begin
                if (pending != '0) begin
                    // fixed priority: line 0 over line 1
                    cur_d   = ~pending[0];
                    state_d = ST_ACK;
                end
            end
            ST_ACK:     state_d = ST_RD_ADDR;
            // peripherals register their decode, so data is only valid in
            // the second cycle the source address is held
            ST_RD_ADDR: state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
                last_data_d = BUS_DATA;
                last_src_d  = cur_q;
                state_d     = ST_WR;
            end
            ST_WR:      state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Outputs decode from state registers only, so nothing on the bus or the
    // ack lines depends combinationally on RAISE.
    always_comb begin
        bus.BUS_ADDR           = IDLE_ADDR;
        bus.BUS_WE             = 1'b0;
        bus.BUS_INTERRUPTS_ACK = '0;
        BUSY                   = (state_q != ST_IDLE);
        DONE                   = 1'b0;
        drive_en               = 1'b0;

        case (state_q)
            ST_ACK:     bus.BUS_INTERRUPTS_ACK[cur_q] = 1'b1;
            ST_RD_ADDR: bus.BUS_ADDR = src_addr(cur_q);
            ST_RD_WAIT: bus.BUS_ADDR = src_addr(cur_q);
            ST_WR: begin
                bus.BUS_ADDR = dst_addr(cur_q);
                bus.BUS_WE   = 1'b1;
                DONE         = 1'b1;
                drive_en     = 1'b1;
            end
            default: ;
        endcase
    end

    // Only the write cycle drives the data bus; a peripheral can only drive
    // it in RD_WAIT, so the two never overlap.
    assign BUS_DATA  = drive_en ? last_data_q : 8'hzz;

    assign LAST_DATA = last_data_q;
    assign LAST_SRC  = last_src_q;

endmodule

// File: tb/tb_bus_irq_servicer.sv
// ----------------------------------------------------------------------------
// tb_bus_irq_servicer
// Bench for bus_irq_servicer with two register-decoded source peripherals.
// ----------------------------------------------------------------------------
module tb_bus_irq_servicer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] enable;
    logic       busy, done, last_src;
    logic [7:0] last_data;
    wire  [7:0] bus_data;

    bus_irq_servicer_if bif();

    bus_irq_servicer dut (
        .CLK       (clk),
        .RESET     (rst_n),
        .BUS_DATA  (bus_data),
        .bus       (bif),
        .ENABLE    (enable),
        .BUSY      (busy),
        .DONE      (done),
        .LAST_DATA (last_data),
        .LAST_SRC  (last_src)
    );

    always #5 clk = ~clk;

    // Source peripherals: registered address decode, drive only in the cycle
    // after their address first appears.
    logic [7:0] src_val [2];
    logic [7:0] a_q, a_qq;
    logic       p_sel0, p_sel1, p_oe;
    logic [7:0] p_val;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= 8'hFF;
            a_qq <= 8'hFF;
        end else begin
            a_q  <= bif.BUS_ADDR;
            a_qq <= a_q;
        end
    end

    assign p_sel0 = (a_q == 8'hA0) && (a_qq != 8'hA0);
    assign p_sel1 = (a_q == 8'hF0) && (a_qq != 8'hF0);
    assign p_oe   = p_sel0 | p_sel1;
    assign p_val  = p_sel0 ? src_val[0] : src_val[1];
    assign bus_data = p_oe ? p_val : 8'hzz;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int wr_count = 0;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Advance one cycle, sample at the falling edge and run the bus monitor.
    task automatic cycle();
        @(negedge clk);
        cyc++;
        if (rst_n) begin
            check("mon_no_clr_addr", {63'd0, bif.BUS_ADDR == 8'hF2}, 64'd0);
            check("mon_no_contention", {63'd0, p_oe && bif.BUS_WE}, 64'd0);
            if (p_oe) check("mon_capture_not_x", {63'd0, $isunknown(bus_data)}, 64'd0);
            if (bif.BUS_WE) wr_count++;
        end
    endtask

    function automatic logic [63:0] outs();
        return {38'd0, bif.BUS_INTERRUPTS_ACK, busy, done, bif.BUS_WE,
                bif.BUS_ADDR, last_src, last_data, (bif.BUS_WE ? bus_data : 8'h00)};
    endfunction

    function automatic logic [63:0] pack(logic [1:0] ack, logic b, logic d, logic we,
                                         logic [7:0] addr, logic ls, logic [7:0] ld,
                                         logic [7:0] wd);
        return {38'd0, ack, b, d, we, addr, ls, ld, wd};
    endfunction

    typedef struct {
        logic [1:0] raise;
        logic [1:0] en;
        logic       svc;
        logic [1:0] exp_ack;
        logic       exp_src;
        logic [7:0] exp_dst;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [7:0] src_tab [2];
        logic [7:0] dst_tab [2];
        int ack_cnt, done_cnt, wr0;
        int start, free_at, line;
        bit act;
        logic [7:0] exp_ld;
        logic       exp_ls;
        logic [1:0] rr, pend;

        src_tab[0] = 8'hA0; src_tab[1] = 8'hF0;
        dst_tab[0] = 8'hB0; dst_tab[1] = 8'h90;

        vecs[0] = '{2'b01, 2'b11, 1'b1, 2'b01, 1'b0, 8'hB0};
        vecs[1] = '{2'b10, 2'b11, 1'b1, 2'b10, 1'b1, 8'h90};
        vecs[2] = '{2'b11, 2'b11, 1'b1, 2'b01, 1'b0, 8'hB0};
        vecs[3] = '{2'b11, 2'b10, 1'b1, 2'b10, 1'b1, 8'h90};
        vecs[4] = '{2'b10, 2'b01, 1'b0, 2'b00, 1'b0, 8'hFF};
        vecs[5] = '{2'b01, 2'b10, 1'b0, 2'b00, 1'b0, 8'hFF};
        vecs[6] = '{2'b00, 2'b11, 1'b0, 2'b00, 1'b0, 8'hFF};
        vecs[7] = '{2'b11, 2'b00, 1'b0, 2'b00, 1'b0, 8'hFF};

        rst_n = 1'b0;
        enable = 2'b00;
        bif.BUS_INTERRUPTS_RAISE = 2'b00;
        src_val[0] = 8'h5C;
        src_val[1] = 8'h2A;

        // reset state
        cycle(); cycle();
        check("reset_outputs", outs(), pack(2'b00, 0, 0, 0, 8'hFF, 0, 8'h00, 8'h00));
        rst_n = 1'b1;
        cycle(); cycle();

        // reset while in RD_WAIT: bus released at once, no write, nothing captured
        enable = 2'b11;
        bif.BUS_INTERRUPTS_RAISE = 2'b10;
        cycle();                         // ACK
        bif.BUS_INTERRUPTS_RAISE = 2'b00;
        check("rst_mid_ack", {62'd0, bif.BUS_INTERRUPTS_ACK}, 64'd2);
        cycle(); cycle();                // RD_WAIT
        check("rst_mid_rdwait_addr", {56'd0, bif.BUS_ADDR}, 64'hF0);
        wr0 = wr_count;
        #1 rst_n = 1'b0;
        #1 check("rst_mid_released", outs(), pack(2'b00, 0, 0, 0, 8'hFF, 0, 8'h00, 8'h00));
        cycle(); cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("rst_mid_idle", outs(), pack(2'b00, 0, 0, 0, 8'hFF, 0, 8'h00, 8'h00));
        end
        check("rst_mid_no_write", wr_count, wr0);

        // table-driven single-shot requests from IDLE
        for (int v = 0; v < 8; v++) begin
            bif.BUS_INTERRUPTS_RAISE = vecs[v].raise;
            enable = vecs[v].en;
            cycle();
            bif.BUS_INTERRUPTS_RAISE = 2'b00;
            check($sformatf("vec%0d_ack", v),
                  {61'd0, busy, bif.BUS_INTERRUPTS_ACK}, {61'd0, vecs[v].svc, vecs[v].exp_ack});
            cycle();
            if (vecs[v].svc)
                check($sformatf("vec%0d_src", v), {56'd0, bif.BUS_ADDR},
                      {56'd0, (vecs[v].exp_src ? 8'hF0 : 8'hA0)});
            cycle(); cycle();
            if (vecs[v].svc)
                check($sformatf("vec%0d_write", v),
                      {46'd0, bif.BUS_WE, done, bif.BUS_ADDR, bus_data},
                      {46'd0, 1'b1, 1'b1, vecs[v].exp_dst, src_val[vecs[v].exp_src]});
            else
                check($sformatf("vec%0d_nowrite", v),
                      {54'd0, bif.BUS_WE, done, bif.BUS_ADDR}, {54'd0, 2'b00, 8'hFF});
            cycle();
            if (vecs[v].svc)
                check($sformatf("vec%0d_last", v), {54'd0, busy, last_src, last_data},
                      {54'd0, 1'b0, vecs[v].exp_src, src_val[vecs[v].exp_src]});
            else
                check($sformatf("vec%0d_idle", v), {63'd0, busy}, 64'd0);
        end

        // both lines together: line 0 first, line 1 acked at k+6
        enable = 2'b11;
        bif.BUS_INTERRUPTS_RAISE = 2'b11;
        cycle();                                               // k+1
        check("both_ack0", {62'd0, bif.BUS_INTERRUPTS_ACK}, 64'd1);
        bif.BUS_INTERRUPTS_RAISE = 2'b10;                      // line 0 cleared by ack
        cycle();
        check("both_rd0", {56'd0, bif.BUS_ADDR}, 64'hA0);
        cycle(); cycle();                                      // k+4
        check("both_wr0", {47'd0, bif.BUS_WE, bif.BUS_ADDR, bus_data}, {47'd0, 1'b1, 8'hB0, 8'h5C});
        cycle();                                               // k+5
        check("both_gap", {61'd0, busy, bif.BUS_INTERRUPTS_ACK}, 64'd0);
        cycle();                                               // k+6
        check("both_ack1", {62'd0, bif.BUS_INTERRUPTS_ACK}, 64'd2);
        bif.BUS_INTERRUPTS_RAISE = 2'b00;
        cycle(); cycle(); cycle();                             // k+9
        check("both_wr1", {47'd0, bif.BUS_WE, bif.BUS_ADDR, bus_data}, {47'd0, 1'b1, 8'h90, 8'h2A});
        cycle();
        check("both_last", {55'd0, last_src, last_data}, {55'd0, 1'b1, 8'h2A});

        // re-raise in the ACK cycle: two complete services
        ack_cnt = 0; done_cnt = 0;
        bif.BUS_INTERRUPTS_RAISE = 2'b10;
        for (int i = 0; i < 15; i++) begin
            cycle();
            if (bif.BUS_INTERRUPTS_ACK == 2'b10) ack_cnt++;
            if (done) done_cnt++;
            if (i == 5) bif.BUS_INTERRUPTS_RAISE = 2'b00;     // second ack seen
        end
        check("reraise_acks", ack_cnt, 2);
        check("reraise_dones", done_cnt, 2);

        // masked line held for 20 cycles
        enable = 2'b01;
        bif.BUS_INTERRUPTS_RAISE = 2'b10;
        for (int i = 0; i < 20; i++) begin
            cycle();
            check("masked_idle", {52'd0, bif.BUS_INTERRUPTS_ACK, busy, bif.BUS_ADDR},
                  {52'd0, 2'b00, 1'b0, 8'hFF});
        end
        bif.BUS_INTERRUPTS_RAISE = 2'b00;
        cycle();

        // randomized traffic against a cycle-timeline model
        src_val[0] = 8'($urandom);
        src_val[1] = 8'($urandom);
        exp_ld = 8'h2A; exp_ls = 1'b1;
        act = 0; start = 0; line = 0; free_at = cyc;
        for (int n = 0; n < 600; n++) begin
            int off;
            off = cyc - start;
            if (act && off >= 1 && off <= 4) begin
                if (off == 4) begin
                    exp_ld = src_val[line];
                    exp_ls = line[0];
                end
                check("rand_busy", outs(),
                      pack((off == 1) ? (2'b01 << line) : 2'b00, 1'b1, off == 4, off == 4,
                           (off == 1) ? 8'hFF : ((off == 4) ? dst_tab[line] : src_tab[line]),
                           exp_ls, exp_ld, (off == 4) ? src_val[line] : 8'h00));
            end else begin
                check("rand_idle", outs(), pack(2'b00, 0, 0, 0, 8'hFF, exp_ls, exp_ld, 8'h00));
            end
            if (n % 16 == 0) enable = 2'($urandom_range(0, 3));
            rr = 2'($urandom_range(0, 3));
            bif.BUS_INTERRUPTS_RAISE = rr;
            pend = rr & enable;
            if (cyc >= free_at && pend != 2'b00) begin
                start = cyc;
                line = pend[0] ? 0 : 1;
                free_at = cyc + 5;
                act = 1;
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bus_irq_servicer.md
# bus_irq_servicer

Hardware bus initiator that services memory-mapped peripheral interrupts without the CPU. It watches two BUS_INTERRUPT_RAISE lines, acknowledges the winning line, reads that source's data register over the shared 8-bit tristate bus, then writes the byte to a per-line destination register. A typical pairing is the timer's value at 0xF0 going to the IR transmitter command register. It sits on the same bus as the peripherals and is the initiator/acknowledger end of their raise/ack and read protocol.

## Interface
- SRC_ADDR0, 8'hA0, source register read when line 0 is serviced
- DST_ADDR0, 8'hB0, destination register written for line 0
- SRC_ADDR1, 8'hF0, source register read when line 1 is serviced (timer value)
- DST_ADDR1, 8'h90, destination register written for line 1
- IDLE_ADDR, 8'hFF, unmapped address driven whenever the block is not accessing the bus; must never equal 0xF2 (timer clear fires on address match alone)
- CLK  in  1  single clock, all state on posedge
- RESET  in  1  asynchronous, active-low reset
- BUS_DATA  inout  8  shared data bus; driven only in WR state, else 8'hZZ
- BUS_ADDR  out  8  bus address
- BUS_WE  out  1  write strobe
- BUS_INTERRUPTS_RAISE  in  2  level interrupt requests from peripherals
- BUS_INTERRUPTS_ACK  out  2  one-cycle acknowledge, one-hot
- ENABLE  in  2  per-line service mask; a masked line is ignored
- BUSY  out  1  high in every state except IDLE
- DONE  out  1  one-cycle pulse during the write cycle
- LAST_DATA  out  8  last byte read
- LAST_SRC  out  1  line index of the last service

## Operation
- FSM states: IDLE, ACK, RD_ADDR, RD_WAIT, WR.
- IDLE: BUS_ADDR=IDLE_ADDR and WE=0. Select pending = RAISE & ENABLE with fixed priority, line 0 over line 1. If any line is pending, latch its index into cur and go to ACK.
- ACK: ACK[cur]=1 for exactly one cycle, then go to RD_ADDR.
- RD_ADDR: BUS_ADDR=SRC[cur], then go to RD_WAIT. Peripherals register their address decode, so data appears one cycle later.
- RD_WAIT: BUS_ADDR=SRC[cur]. At the closing edge, capture BUS_DATA into LAST_DATA and set LAST_SRC=cur. Then go to WR.
- WR: BUS_ADDR=DST[cur], BUS_WE=1, BUS_DATA drives the captured byte, DONE=1. Then go to IDLE.
- Requests are not latched. A line that drops before IDLE samples it is lost, by design.
- If a peripheral re-raises in the same cycle it sees ACK (raise has priority over ack in peripherals), the line is still high on return to IDLE and is serviced again.
- Nothing is serviced while BUSY. A line raised during a service waits for IDLE.
- Reset mid-operation returns the block to IDLE immediately (asynchronous): bus released, ACK cleared, no partial write.

## Timing
- Reset values: BUS_ADDR=IDLE_ADDR, BUS_WE=0, BUS_DATA=Z, ACK=2'b00, BUSY=0, DONE=0, LAST_DATA=8'h00, LAST_SRC=0, state IDLE.
- Raise sampled at edge k gives ACK in cycle k+1, source address in cycles k+2 and k+3, data capture at end of k+3, write in cycle k+4, IDLE in k+5.
- Service length is 4 cycles. Best-case back-to-back services start every 5 cycles.
- All outputs are registered from state: no combinational path from RAISE to ACK or to any bus output.
- The block never drives BUS_DATA in the same cycle a peripheral can drive it. The only peripheral drive window is the cycle after RD_ADDR, and the block only drives in WR.

## Structure
- Package bus_map_pkg holds:
  - the state enum (3-bit);
  - IDLE_ADDR and the shared memory-map constants (0xF0 timer base, 0x90 IR command), also reused by the timer and IR blocks;
  - the NUM_IRQ=2 constant.
- Single module. The priority select is a two-line inline expression, so no sub-module is warranted.

## Test plan
- Timer model holding 8'h2A at 0xF0 raises line 1 with ENABLE=2'b11 → ACK=2'b10 one cycle later; write 0x2A to 0x90 four cycles after sampling; LAST_SRC=1; DONE pulses once.
- Both lines raised in the same cycle → line 0 served first: read 0xA0, write 0xB0. Line 1 served next: ACK[1] at cycle k+6.
- ENABLE=2'b01 with line 1 held high for 20 cycles → no ACK, BUSY stays 0, BUS_ADDR stays 0xFF throughout.
- Peripheral re-raises in the ACK cycle → exactly two complete services, each with its own ACK and DONE.
- RESET asserted low in RD_WAIT → same-cycle BUS_ADDR=0xFF, WE=0, BUS_DATA=Z; LAST_DATA unchanged; no write to DST.
- Bus monitor over all tests → 0xF2 is never addressed, BUS_DATA is never driven by two sources at once, and BUS_DATA is never X at the capture edge.
